// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART byte serializer among NUM_REQ
// byte-stream requesters, with a forced release at MAX_PKT_LEN and an idle gap per packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT_LEN = 64,
  parameter int GAP_CYCLES  = 434,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   uart_valid,
  output logic [7:0]             uart_data,
  input  logic                   uart_ready,
  output logic                   grant_active,
  output logic [ID_W-1:0]        grant_id,
  output logic                   pkt_abort
);

  localparam int GAP_W    = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   last_grant;
  logic [7:0]        byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic              arb_found;
  logic [ID_W-1:0]   arb_winner;
  logic [ID_W-1:0]   cand;
  logic              handshake;
  logic              cur_last;
  logic              pkt_force;
  logic              pkt_end;

  // Round-robin scan starting just after the previous owner, so it ends up last in line.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    arb_found  = 1'b0;
    arb_winner = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  assign handshake = uart_valid & uart_ready;
  assign cur_last  = req_last[grant_id];
  // A byte carrying req_last always ends normally, even when it also hits the length limit.
  assign pkt_force = handshake & ~cur_last & (byte_cnt == 8'(MAX_PKT_LEN - 1));
  assign pkt_end   = (handshake & cur_last) | pkt_force;

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!tx_rst_n) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (arb_found) next_state = XFER;
      XFER: if (pkt_end)   next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Zero-bubble passthrough: the owner's byte stream is wired straight to the serializer.
  always_comb begin
    grant_active = 1'b0;
    uart_valid   = 1'b0;
    uart_data    = 8'h00;
    req_ready    = '0;
    if (state == XFER) begin
      grant_active        = 1'b1;
      uart_valid          = req_valid[grant_id];
      uart_data           = req_data[{grant_id, 3'b000} +: 8];
      req_ready[grant_id] = uart_ready;
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      byte_cnt   <= 8'd0;
      gap_cnt    <= '0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_abort <= pkt_force;
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id   <= arb_winner;
            last_grant <= arb_winner;
            byte_cnt   <= 8'd0;
          end
        end
        XFER: begin
          if (handshake) byte_cnt <= byte_cnt + 8'd1;
          if (pkt_end)   gap_cnt  <= GAP_W'(GAP_LOAD);
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (MAX 4 / GAP 4 and MAX 3 / GAP 0),
// bench-side requester queues and a per-instance scoreboard of expected output bytes.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid  [2];
  logic [31:0] req_data   [2];
  logic [3:0]  req_last   [2];
  logic [3:0]  req_ready  [2];
  logic        uart_valid [2];
  logic [7:0]  uart_data  [2];
  logic        uart_ready [2];
  logic        grant_active [2];
  logic [1:0]  grant_id   [2];
  logic        pkt_abort  [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] src_mem  [2][4][16];
  int         src_head [2][4];
  int         src_tail [2][4];

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  int   hs_cyc    [2][32];
  int   hs_n      [2];
  int   abort_cyc [2][8];
  int   abort_n   [2];
  logic rdy_chk_en;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT_LEN(4), .GAP_CYCLES(4)) dut_a (
    .tx_clk(clk), .tx_rst_n(rst_n),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .req_ready(req_ready[0]), .uart_valid(uart_valid[0]), .uart_data(uart_data[0]),
    .uart_ready(uart_ready[0]), .grant_active(grant_active[0]), .grant_id(grant_id[0]),
    .pkt_abort(pkt_abort[0])
  );

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT_LEN(3), .GAP_CYCLES(0)) dut_b (
    .tx_clk(clk), .tx_rst_n(rst_n),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .req_ready(req_ready[1]), .uart_valid(uart_valid[1]), .uart_data(uart_data[1]),
    .uart_ready(uart_ready[1]), .grant_active(grant_active[1]), .grant_id(grant_id[1]),
    .pkt_abort(pkt_abort[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push_src(input int d, input int r, input logic [7:0] data, input logic last);
    src_mem[d][r][src_tail[d][r]] = {last, data};
    src_tail[d][r]++;
  endtask

  task automatic expect_byte(input int d, input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    if (d == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  function automatic int sb_size(input int d);
    return (d == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  task automatic drive();
    logic [8:0] w;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 4; r++) begin
        if (src_head[d][r] < src_tail[d][r]) begin
          w = src_mem[d][r][src_head[d][r]];
          req_valid[d][r]       = 1'b1;
          req_data[d][8*r +: 8] = w[7:0];
          req_last[d][r]        = w[8];
        end else begin
          req_valid[d][r]       = 1'b0;
          req_data[d][8*r +: 8] = 8'h00;
          req_last[d][r]        = 1'b0;
        end
      end
    end
  endtask

  // One clock: observe at the falling edge, advance requester queues just after the rising edge.
  task automatic step();
    logic [3:0] acc [2];
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = req_valid[d] & req_ready[d];
      if (pkt_abort[d]) begin
        if (abort_n[d] < 8) abort_cyc[d][abort_n[d]] = cyc;
        abort_n[d]++;
      end
      if (uart_valid[d] && uart_ready[d]) begin
        if (hs_n[d] < 32) hs_cyc[d][hs_n[d]] = cyc;
        hs_n[d]++;
        if (sb_size(d) == 0) begin
          check($sformatf("sb_unexpected_byte_d%0d", d), {24'd0, uart_data[d]}, 32'h100);
        end else begin
          if (d == 0) e = exp_q_a.pop_front();
          else        e = exp_q_b.pop_front();
          check($sformatf("sb_data_d%0d", d), {24'd0, uart_data[d]}, {24'd0, e.data});
          check($sformatf("sb_grant_id_d%0d", d), {30'd0, grant_id[d]}, {30'd0, e.id});
        end
      end
    end
    if (rdy_chk_en)
      check("req_ready_mirror", {28'd0, req_ready[0]}, uart_ready[0] ? 32'h8 : 32'h0);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 4; r++)
        if (acc[d][r]) src_head[d][r]++;
    drive();
  endtask

  task automatic run_until_done(input int d, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb_size(d) == 0) break;
      step();
    end
    check($sformatf("drain_d%0d_remaining", d), sb_size(d), 0);
  endtask

  task automatic wait_grant(input int d, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (grant_active[d]) break;
      step();
    end
    check($sformatf("wait_grant_d%0d", d), {31'd0, grant_active[d]}, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    rdy_chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      uart_ready[d] = 1'b1;
      hs_n[d]       = 0;
      abort_n[d]    = 0;
      for (int r = 0; r < 4; r++) begin
        src_head[d][r] = 0;
        src_tail[d][r] = 0;
      end
    end

    // Reset with every requester valid; then round-robin 0,1,2,3,0 with 1-byte packets.
    for (int r = 0; r < 4; r++) begin
      push_src(0, r, 8'hA0 + 8'(r), 1'b1);
      expect_byte(0, 2'(r), 8'hA0 + 8'(r));
    end
    push_src(0, 0, 8'hA4, 1'b1);
    expect_byte(0, 2'd0, 8'hA4);
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant_active", {31'd0, grant_active[0]}, 0);
    check("rst_uart_valid",   {31'd0, uart_valid[0]}, 0);
    check("rst_uart_data",    {24'd0, uart_data[0]}, 0);
    check("rst_req_ready",    {28'd0, req_ready[0]}, 0);
    check("rst_grant_id",     {30'd0, grant_id[0]}, 0);
    check("rst_pkt_abort",    {31'd0, pkt_abort[0]}, 0);
    rst_n = 1'b1;
    run_until_done(0, 100);
    check("rr_hs_count", hs_n[0], 5);
    // Handshake edges are G+2 apart: G gap cycles, one IDLE cycle, then the grant cycle.
    for (int i = 1; i < hs_n[0] && i < 32; i++)
      check($sformatf("rr_spacing_%0d", i), hs_cyc[0][i] - hs_cyc[0][i-1], 6);

    // "QRST" from requester 2 while 0 and 1 keep requesting; last byte also hits MAX_PKT_LEN.
    hs_n[0]    = 0;
    abort_n[0] = 0;
    push_src(0, 2, 8'h51, 1'b0);
    push_src(0, 2, 8'h52, 1'b0);
    push_src(0, 2, 8'h53, 1'b0);
    push_src(0, 2, 8'h54, 1'b1);
    push_src(0, 0, 8'hC0, 1'b1);
    push_src(0, 0, 8'hC1, 1'b1);
    push_src(0, 1, 8'hD0, 1'b1);
    push_src(0, 1, 8'hD1, 1'b1);
    expect_byte(0, 2'd1, 8'hD0);
    expect_byte(0, 2'd2, 8'h51);
    expect_byte(0, 2'd2, 8'h52);
    expect_byte(0, 2'd2, 8'h53);
    expect_byte(0, 2'd2, 8'h54);
    expect_byte(0, 2'd0, 8'hC0);
    expect_byte(0, 2'd1, 8'hD1);
    expect_byte(0, 2'd0, 8'hC1);
    drive();
    run_until_done(0, 200);
    check("qrst_hs_count", hs_n[0], 8);
    for (int i = 2; i <= 4 && i < hs_n[0]; i++)
      check($sformatf("qrst_contiguous_%0d", i), hs_cyc[0][i] - hs_cyc[0][i-1], 1);
    check("qrst_no_abort", abort_n[0], 0);

    // Back-pressure pattern 1,0,0,1,1 on a 3-byte packet from requester 3.
    hs_n[0] = 0;
    push_src(0, 3, 8'hE0, 1'b0);
    push_src(0, 3, 8'hE1, 1'b0);
    push_src(0, 3, 8'hE2, 1'b1);
    expect_byte(0, 2'd3, 8'hE0);
    expect_byte(0, 2'd3, 8'hE1);
    expect_byte(0, 2'd3, 8'hE2);
    drive();
    uart_ready[0] = 1'b0;
    wait_grant(0, 20);
    rdy_chk_en = 1'b1;
    uart_ready[0] = 1'b1; step();
    uart_ready[0] = 1'b0; step();
    uart_ready[0] = 1'b0; step();
    uart_ready[0] = 1'b1; step();
    uart_ready[0] = 1'b1; step();
    rdy_chk_en = 1'b0;
    check("bp_hs_count", hs_n[0], 3);
    check("bp_stall_span", hs_cyc[0][1] - hs_cyc[0][0], 3);
    check("bp_resume_span", hs_cyc[0][2] - hs_cyc[0][1], 1);
    check("bp_remaining", sb_size(0), 0);

    // Reset pulse while byte 2 of a 4-byte packet from requester 3 is on offer.
    push_src(0, 3, 8'hF0, 1'b0);
    push_src(0, 3, 8'hF1, 1'b0);
    push_src(0, 3, 8'hF2, 1'b0);
    push_src(0, 3, 8'hF3, 1'b1);
    expect_byte(0, 2'd3, 8'hF0);
    drive();
    uart_ready[0] = 1'b0;
    wait_grant(0, 20);
    uart_ready[0] = 1'b1;
    step();
    check("pre_rst_uart_valid", {31'd0, uart_valid[0]}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uart_valid",   {31'd0, uart_valid[0]}, 0);
    check("async_rst_grant_active", {31'd0, grant_active[0]}, 0);
    check("async_rst_req_ready",    {28'd0, req_ready[0]}, 0);
    check("async_rst_grant_id",     {30'd0, grant_id[0]}, 0);
    src_head[0][3] = src_tail[0][3];
    push_src(0, 1, 8'h4B, 1'b1);
    push_src(0, 0, 8'h47, 1'b1);
    expect_byte(0, 2'd0, 8'h47);
    expect_byte(0, 2'd1, 8'h4B);
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_until_done(0, 100);

    // Zero gap: two single-byte packets back to back, one IDLE cycle between handshakes.
    hs_n[1] = 0;
    push_src(1, 0, 8'h30, 1'b1);
    push_src(1, 2, 8'h32, 1'b1);
    expect_byte(1, 2'd0, 8'h30);
    expect_byte(1, 2'd2, 8'h32);
    drive();
    run_until_done(1, 40);
    check("gap0_hs_count", hs_n[1], 2);
    check("gap0_spacing", hs_cyc[1][1] - hs_cyc[1][0], 2);

    // MAX_PKT_LEN = 3: five bytes without req_last from requester 1.
    hs_n[1]    = 0;
    abort_n[1] = 0;
    for (int i = 0; i < 5; i++) begin
      push_src(1, 1, 8'h60 + 8'(i), 1'b0);
      expect_byte(1, 2'd1, 8'h60 + 8'(i));
    end
    drive();
    run_until_done(1, 60);
    repeat (3) step();
    check("abort_hs_count", hs_n[1], 5);
    check("abort_pulse_count", abort_n[1], 1);
    check("abort_pulse_cycle", abort_cyc[1][0], hs_cyc[1][2] + 1);
    check("abort_regrant_spacing", hs_cyc[1][3] - hs_cyc[1][2], 2);
    check("idle_owner_keeps_grant", {31'd0, grant_active[1]}, 1);
    check("idle_owner_grant_id", {30'd0, grant_id[1]}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
